// File: rtl/sync_fifo_fwft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_fwft_pkg
//  Purpose  : Shared definitions for the first-word-fall-through FIFO:
//             address-width helper and the registered status flag bundle.
//  Revision : 1.0  initial release
// ============================================================================
package sync_fifo_fwft_pkg;

    // Ceiling log2, usable in constant expressions for address widths.
    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Registered status flags, all updated on the same clock edge.
    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic ovf;
        logic udf;
    } fifo_flags_t;

    // Bit positions of each flag inside the packed bundle.
    localparam int c_flag_udf         = 0;
    localparam int c_flag_ovf         = 1;
    localparam int c_flag_empty       = 2;
    localparam int c_flag_almost_full = 3;
    localparam int c_flag_full        = 4;

    localparam fifo_flags_t c_flags_reset = '{
        full:        1'b0,
        almost_full: 1'b0,
        empty:       1'b1,
        ovf:         1'b0,
        udf:         1'b0
    };

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram_sdp
//  Purpose  : Simple dual-port storage for the FIFO. Synchronous write,
//             registered read (read-before-write on an address collision).
//             No reset: contents are only meaningful once written.
//  Ports    : i_clk      clock
//             i_wr_en    write strobe
//             i_wr_addr  write address
//             i_wr_data  write data
//             i_rd_addr  read address, sampled every cycle
//             o_rd_data  registered read data (old contents on collision)
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ram_sdp
    import sync_fifo_fwft_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = f_clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_fwft
//  Purpose  : Single-clock FIFO with first-word-fall-through output and a
//             valid/ready read side, occupancy count and sticky error flags.
//  Ports    : CLK          clock, rising edge
//             RST_N        asynchronous reset, active low
//             CLR          synchronous flush (also clears sticky flags)
//             DIN/DIN_DV   write data / write request (ignored when FULL)
//             FULL         no write accepted this cycle
//             ALMOST_FULL  COUNT >= AF_LEVEL
//             DOUT/DOUT_DV head word / head word valid (== !EMPTY)
//             DOUT_RDY     consumer pops head when DOUT_DV && DOUT_RDY
//             EMPTY        no words stored
//             COUNT        words stored, 0..DEPTH
//             OVF / UDF    sticky: write while full / ready while empty
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        CLR,
    input  logic [WIDTH-1:0]            DIN,
    input  logic                        DIN_DV,
    output logic                        FULL,
    output logic                        ALMOST_FULL,
    output logic [WIDTH-1:0]            DOUT,
    output logic                        DOUT_DV,
    input  logic                        DOUT_RDY,
    output logic                        EMPTY,
    output logic [f_clog2(DEPTH):0]     COUNT,
    output logic                        OVF,
    output logic                        UDF
);

    localparam int          AW           = f_clog2(DEPTH);
    localparam logic [AW:0] c_count_full = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_count_af   = (AW+1)'(AF_LEVEL);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    fifo_flags_t      r_flags;
    fifo_flags_t      w_flags_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_byp_nxt;
    logic             r_byp;
    logic [WIDTH-1:0] r_byp_data;
    logic [WIDTH-1:0] w_ram_q;

    always_comb begin
        w_push       = DIN_DV && !r_flags.full;
        w_pop        = !r_flags.empty && DOUT_RDY;
        w_wr_ptr_nxt = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
        w_rd_ptr_nxt = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase

        w_flags_nxt.full        = (w_count_nxt == c_count_full);
        w_flags_nxt.almost_full = (w_count_nxt >= c_count_af);
        w_flags_nxt.empty       = (w_count_nxt == '0);
        w_flags_nxt.ovf         = r_flags.ovf | (DIN_DV && r_flags.full);
        w_flags_nxt.udf         = r_flags.udf | (DOUT_RDY && r_flags.empty);

        // The RAM is always reading the slot that will be the head after this
        // edge. If that same slot is being written now (push into an empty
        // FIFO, or push+pop with one word stored) the registered read returns
        // stale data, so the incoming word is captured and shown instead for
        // one cycle; by the following edge the RAM read has caught up.
        w_byp_nxt = w_push && (r_wr_ptr == w_rd_ptr_nxt);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_flags    <= c_flags_reset;
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else if (CLR) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_flags    <= c_flags_reset;
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_flags    <= w_flags_nxt;
            r_byp      <= w_byp_nxt;
            if (w_byp_nxt) begin
                r_byp_data <= DIN;
            end
        end
    end

    fifo_ram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (CLK),
        .i_wr_en   (w_push && !CLR),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (DIN),
        .i_rd_addr (w_rd_ptr_nxt),
        .o_rd_data (w_ram_q)
    );

    // Head word is forced to zero while nothing is stored so DOUT is never
    // driven from uninitialised RAM contents.
    assign DOUT        = r_flags.empty ? '0 : (r_byp ? r_byp_data : w_ram_q);
    assign DOUT_DV     = !r_flags.empty;
    assign EMPTY       = r_flags.empty;
    assign FULL        = r_flags.full;
    assign ALMOST_FULL = r_flags.almost_full;
    assign OVF         = r_flags.ovf;
    assign UDF         = r_flags.udf;
    assign COUNT       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_fwft
//  Purpose  : Self-checking bench for sync_fifo_fwft (WIDTH=8, DEPTH=16,
//             AF_LEVEL=12): vector table, directed corner sequences and
//             randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_fwft;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             CLR;
    logic [WIDTH-1:0] DIN;
    logic             DIN_DV;
    logic             FULL;
    logic             ALMOST_FULL;
    logic [WIDTH-1:0] DOUT;
    logic             DOUT_DV;
    logic             DOUT_RDY;
    logic             EMPTY;
    logic [4:0]       COUNT;
    logic             OVF;
    logic             UDF;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: stored words in order plus the two sticky flags.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_udf;

    typedef struct {
        logic             dv;
        logic [WIDTH-1:0] din;
        logic             rdy;
        logic [4:0]       exp_count;
        logic             exp_full;
        logic             exp_af;
        logic             exp_ovf;
        logic [WIDTH-1:0] exp_dout;
    } vec_t;

    vec_t vt[33];

    always #5 CLK = ~CLK;

    sync_fifo_fwft #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .CLR         (CLR),
        .DIN         (DIN),
        .DIN_DV      (DIN_DV),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .DOUT        (DOUT),
        .DOUT_DV     (DOUT_DV),
        .DOUT_RDY    (DOUT_RDY),
        .EMPTY       (EMPTY),
        .COUNT       (COUNT),
        .OVF         (OVF),
        .UDF         (UDF)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = m_q.size();
        chk("count",   32'(COUNT),       32'(sz));
        chk("empty",   32'(EMPTY),       32'(sz == 0));
        chk("dout_dv", 32'(DOUT_DV),     32'(sz != 0));
        chk("full",    32'(FULL),        32'(sz == DEPTH));
        chk("afull",   32'(ALMOST_FULL), 32'(sz >= AF_LEVEL));
        chk("ovf",     32'(OVF),         32'(m_ovf));
        chk("udf",     32'(UDF),         32'(m_udf));
        if (sz != 0) begin
            chk("dout", 32'(DOUT), 32'(m_q[0]));
        end
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, check.
    task automatic step(input logic dv, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        bit m_full;
        bit push;
        bit pop;
        DIN_DV   = dv;
        DIN      = d;
        DOUT_RDY = rdy;
        CLR      = clr;
        @(posedge CLK);
        m_full = (m_q.size() == DEPTH);
        push   = dv && !m_full;
        pop    = (m_q.size() != 0) && rdy;
        if (clr) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (dv && m_full)              m_ovf = 1;
            if (rdy && m_q.size() == 0)    m_udf = 1;
            if (pop)                       void'(m_q.pop_front());
            if (push)                      m_q.push_back(d);
        end
        #1;
        check_model();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4 && m_q.size() != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(EMPTY), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        // Fill 0x01..0x10, overflow with 0xAA, then drain one per cycle.
        for (int i = 0; i < 16; i++) begin
            vt[i] = '{dv: 1'b1, din: 8'(i + 1), rdy: 1'b0, exp_count: 5'(i + 1),
                      exp_full: (i == 15), exp_af: (i + 1 >= AF_LEVEL),
                      exp_ovf: 1'b0, exp_dout: 8'h01};
        end
        vt[16] = '{dv: 1'b1, din: 8'hAA, rdy: 1'b0, exp_count: 5'd16,
                   exp_full: 1'b1, exp_af: 1'b1, exp_ovf: 1'b1, exp_dout: 8'h01};
        for (int k = 1; k <= 16; k++) begin
            vt[16 + k] = '{dv: 1'b0, din: 8'h00, rdy: 1'b1, exp_count: 5'(16 - k),
                           exp_full: 1'b0, exp_af: (16 - k >= AF_LEVEL),
                           exp_ovf: 1'b1, exp_dout: 8'(k + 1)};
        end

        RST_N = 1'b0; CLR = 1'b0; DIN = '0; DIN_DV = 1'b0; DOUT_RDY = 1'b0;
        m_ovf = 0; m_udf = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst_count",   32'(COUNT),       32'd0);
        chk("rst_empty",   32'(EMPTY),       32'd1);
        chk("rst_dout_dv", 32'(DOUT_DV),     32'd0);
        chk("rst_full",    32'(FULL),        32'd0);
        chk("rst_afull",   32'(ALMOST_FULL), 32'd0);
        chk("rst_ovf",     32'(OVF),         32'd0);
        chk("rst_udf",     32'(UDF),         32'd0);
        chk("rst_dout",    32'(DOUT),        32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Vector table.
        for (int i = 0; i < 33; i++) begin
            step(vt[i].dv, vt[i].din, vt[i].rdy, 1'b0);
            chk("tbl_count", 32'(COUNT),       32'(vt[i].exp_count));
            chk("tbl_full",  32'(FULL),        32'(vt[i].exp_full));
            chk("tbl_afull", 32'(ALMOST_FULL), 32'(vt[i].exp_af));
            chk("tbl_ovf",   32'(OVF),         32'(vt[i].exp_ovf));
            chk("tbl_dv",    32'(DOUT_DV),     32'(vt[i].exp_count != 0));
            if (vt[i].exp_count != 0) begin
                chk("tbl_dout", 32'(DOUT), 32'(vt[i].exp_dout));
            end
        end

        // First-word fall-through and hold while not ready.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_dv",   32'(DOUT_DV), 32'd1);
        chk("fwft_dout", 32'(DOUT),    32'h5A);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'hFF, 1'b0, 1'b0);
            chk("hold_dout", 32'(DOUT), 32'h5A);
            chk("hold_dv",   32'(DOUT_DV), 32'd1);
        end
        drain();

        // Simultaneous push/pop at COUNT=1, then at COUNT=8 (pointer wrap).
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            chk("pp1_count", 32'(COUNT), 32'd1);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            chk("pp8_count", 32'(COUNT), 32'd8);
        end
        drain();

        // Asynchronous reset mid-stream at COUNT=7.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        end
        chk("pre_rst_count", 32'(COUNT), 32'd7);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("arst_count", 32'(COUNT),   32'd0);
        chk("arst_empty", 32'(EMPTY),   32'd1);
        chk("arst_dv",    32'(DOUT_DV), 32'd0);
        m_q.delete(); m_ovf = 0; m_udf = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // CLR at COUNT=5 with OVF set.
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 11; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("pre_clr_count", 32'(COUNT), 32'd5);
        chk("pre_clr_ovf",   32'(OVF),   32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        chk("clr_count", 32'(COUNT), 32'd0);
        chk("clr_ovf",   32'(OVF),   32'd0);
        chk("clr_empty", 32'(EMPTY), 32'd1);

        // Randomized traffic in fill / balanced / drain phases.
        for (int i = 0; i < 900; i++) begin
            int ph;
            logic dv;
            logic rdy;
            ph  = (i / 100) % 3;
            dv  = (ph == 0) ? ($urandom_range(0, 3) != 0) :
                  (ph == 1) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
            rdy = (ph == 0) ? ($urandom_range(0, 3) == 0) :
                  (ph == 1) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
            step(dv, 8'($urandom), rdy, ($urandom_range(0, 149) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
